sd_spi_responder: RTL and testbench

- SPI-mode SD card responder: the card-side counterpart of our SD host init/read path.
- Receives 48-bit command frames on sd_mosi/sd_ck/sd_csn and drives R1/R3/R7 responses and single-block read data on sd_miso.
- Used as a synthesizable card model in simulation and FPGA loopback, running on the 50 MHz system clock and oversampling the host's divided sd_ck.

---
 rtl/sd_spi_responder.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card responder (card side of the host init/read path).
// Oversamples the host's sd_ck on clk, decodes 48-bit command frames and answers with
// R1/R3/R7 responses and single 512-byte read blocks fetched through dat_req/dat_in.
// Optional build macro: SD_CRC_CHECK_EN -- verify the CRC7 of each command frame and
// answer a mismatch with an error R1 and no other effect.
module sd_spi_responder #(
    parameter int          INIT_RETRIES = 3,
    parameter int          NCR_BYTES    = 1,
    parameter logic [31:0] OCR_VALUE    = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_ck,
    input  logic        sd_csn,
    input  logic        sd_mosi,
    output logic        sd_miso,
    output logic        init_done,
    output logic [31:0] blk_addr,
    output logic        dat_req,
    input  logic [7:0]  dat_in
);

    typedef enum logic [3:0] {
        ST_HUNT, ST_RX, ST_DECODE, ST_NCR, ST_RESP,
        ST_DGAP, ST_TOKEN, ST_DATA, ST_DCRC
    } state_t;

    localparam logic [6:0] NCR_BITS   = 7'(NCR_BYTES * 8);
    localparam logic [7:0] RETRY_LOAD = 8'(INIT_RETRIES);

    // Synchronizers; ck_sync_q[2] is the previous synchronized sd_ck for edge detection
    logic [2:0] ck_sync_q;
    logic [1:0] csn_sync_q;
    logic [1:0] mosi_sync_q;
    logic       csn_s, mosi_s, ck_rise, ck_fall;

    state_t      state_q, state_d;
    logic [45:0] rx_sr_q, rx_sr_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic        got_zero_q, got_zero_d;
    logic [39:0] out_sr_q, out_sr_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  resp_len_q, resp_len_d;
    logic        has_data_q, has_data_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic        miso_q, miso_d;
    logic        dat_req_q, dat_req_d;
    logic        idle_q, idle_d;
    logic [7:0]  acmd_cnt_q, acmd_cnt_d;
    logic        app_q, app_d;
    logic        init_done_q, init_done_d;
    logic [31:0] blk_addr_q, blk_addr_d;

    logic [5:0]  frm_cmd;
    logic [31:0] frm_arg;
    logic        crc_ok;
    logic [7:0]  r1_idle;
    logic [31:0] ocr_now;
    logic        last_bit;

    // Two-flop synchronizers for the host pins plus one extra stage of sd_ck for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_sync_q   <= 3'b000;
            csn_sync_q  <= 2'b11;
            mosi_sync_q <= 2'b11;
        end else begin
            ck_sync_q   <= {ck_sync_q[1:0], sd_ck};
            csn_sync_q  <= {csn_sync_q[0], sd_csn};
            mosi_sync_q <= {mosi_sync_q[0], sd_mosi};
        end
    end

    assign csn_s   = csn_sync_q[1];
    assign mosi_s  = mosi_sync_q[1];
    assign ck_rise =  ck_sync_q[1] & ~ck_sync_q[2] & ~csn_s;
    assign ck_fall = ~ck_sync_q[1] &  ck_sync_q[2] & ~csn_s;

    // Frame fields once all 46 bits after start/transmission are shifted in
    assign frm_cmd  = rx_sr_q[45:40];
    assign frm_arg  = rx_sr_q[39:8];
    assign r1_idle  = {7'b0, idle_q};
    assign ocr_now  = {OCR_VALUE[31], ~idle_q, OCR_VALUE[29:0]};
    assign last_bit = (bit_cnt_q == 7'd1);

`ifdef SD_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign crc_ok = (crc7({2'b01, frm_cmd, frm_arg}) == rx_sr_q[7:1]);
`else
    assign crc_ok = 1'b1;
`endif

    // Next-state logic: frame reception, command decode and bit-serial response shifting
    always_comb begin
        state_d     = state_q;
        rx_sr_d     = rx_sr_q;
        rx_cnt_d    = rx_cnt_q;
        got_zero_d  = got_zero_q;
        out_sr_d    = out_sr_q;
        bit_cnt_d   = bit_cnt_q;
        resp_len_d  = resp_len_q;
        has_data_d  = has_data_q;
        byte_cnt_d  = byte_cnt_q;
        miso_d      = miso_q;
        dat_req_d   = 1'b0;
        idle_d      = idle_q;
        acmd_cnt_d  = acmd_cnt_q;
        app_d       = app_q;
        init_done_d = init_done_q;
        blk_addr_d  = blk_addr_q;

        // The byte requested on the previous clk lands in the top of the shifter
        if (dat_req_q) out_sr_d[39:32] = dat_in;

        if (csn_s) begin
            state_d    = ST_HUNT;
            miso_d     = 1'b1;
            got_zero_d = 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (ck_fall) miso_d = 1'b1;
                    if (ck_rise) begin
                        if (!mosi_s) begin
                            got_zero_d = 1'b1;
                        end else if (got_zero_q) begin
                            got_zero_d = 1'b0;
                            rx_cnt_d   = 6'd0;
                            state_d    = ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (ck_fall) miso_d = 1'b1;
                    if (ck_rise) begin
                        rx_sr_d  = {rx_sr_q[44:0], mosi_s};
                        rx_cnt_d = rx_cnt_q + 6'd1;
                        // Last bit is the stop bit; a 0 there drops the frame silently
                        if (rx_cnt_q == 6'd45) state_d = mosi_s ? ST_DECODE : ST_HUNT;
                    end
                end
                ST_DECODE: begin
                    state_d    = ST_NCR;
                    bit_cnt_d  = NCR_BITS;
                    resp_len_d = 7'd8;
                    has_data_d = 1'b0;
                    out_sr_d   = {r1_idle | 8'h04, 32'h0};
                    if (!crc_ok) begin
                        out_sr_d = {r1_idle | 8'h08, 32'h0};
                    end else begin
                        app_d = 1'b0;
                        case (frm_cmd)
                            6'd0: begin
                                out_sr_d    = {8'h01, 32'h0};
                                idle_d      = 1'b1;
                                init_done_d = 1'b0;
                                acmd_cnt_d  = RETRY_LOAD;
                            end
                            6'd8: begin
                                out_sr_d   = {r1_idle, 20'h0, frm_arg[11:0]};
                                resp_len_d = 7'd40;
                            end
                            6'd55: begin
                                out_sr_d = {r1_idle, 32'h0};
                                app_d    = 1'b1;
                            end
                            6'd41: begin
                                if (app_q) begin
                                    if (acmd_cnt_q != 8'd0) begin
                                        acmd_cnt_d = acmd_cnt_q - 8'd1;
                                        out_sr_d   = {8'h01, 32'h0};
                                    end else begin
                                        out_sr_d    = {8'h00, 32'h0};
                                        idle_d      = 1'b0;
                                        init_done_d = 1'b1;
                                    end
                                end
                            end
                            6'd58: begin
                                out_sr_d   = {r1_idle, ocr_now};
                                resp_len_d = 7'd40;
                            end
                            6'd17: begin
                                if (idle_q) begin
                                    out_sr_d = {8'h05, 32'h0};
                                end else begin
                                    out_sr_d   = {8'h00, 32'h0};
                                    blk_addr_d = frm_arg;
                                    has_data_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_NCR: begin
                    if (ck_fall) begin
                        miso_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (last_bit) begin
                            state_d   = ST_RESP;
                            bit_cnt_d = resp_len_q;
                        end
                    end
                end
                ST_RESP: begin
                    if (ck_fall) begin
                        miso_d    = out_sr_q[39];
                        out_sr_d  = {out_sr_q[38:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (last_bit) begin
                            state_d   = has_data_q ? ST_DGAP : ST_HUNT;
                            bit_cnt_d = 7'd8;
                        end
                    end
                end
                ST_DGAP: begin
                    if (ck_fall) begin
                        miso_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (last_bit) begin
                            state_d   = ST_TOKEN;
                            bit_cnt_d = 7'd8;
                            out_sr_d  = {8'hFE, 32'h0};
                        end
                    end
                end
                ST_TOKEN: begin
                    if (ck_fall) begin
                        miso_d    = out_sr_q[39];
                        out_sr_d  = {out_sr_q[38:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (last_bit) begin
                            state_d    = ST_DATA;
                            bit_cnt_d  = 7'd8;
                            byte_cnt_d = 9'd0;
                            dat_req_d  = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (ck_fall) begin
                        miso_d    = out_sr_q[39];
                        out_sr_d  = {out_sr_q[38:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (last_bit) begin
                            bit_cnt_d  = 7'd8;
                            byte_cnt_d = byte_cnt_q + 9'd1;
                            // No request after the final byte: 512 requests per block
                            if (byte_cnt_q == 9'd511) begin
                                state_d   = ST_DCRC;
                                bit_cnt_d = 7'd16;
                            end else begin
                                dat_req_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DCRC: begin
                    if (ck_fall) begin
                        miso_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (last_bit) state_d = ST_HUNT;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State and card-status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            rx_sr_q     <= '0;
            rx_cnt_q    <= '0;
            got_zero_q  <= 1'b0;
            out_sr_q    <= '0;
            bit_cnt_q   <= '0;
            resp_len_q  <= 7'd8;
            has_data_q  <= 1'b0;
            byte_cnt_q  <= '0;
            miso_q      <= 1'b1;
            dat_req_q   <= 1'b0;
            idle_q      <= 1'b1;
            acmd_cnt_q  <= RETRY_LOAD;
            app_q       <= 1'b0;
            init_done_q <= 1'b0;
            blk_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            rx_sr_q     <= rx_sr_d;
            rx_cnt_q    <= rx_cnt_d;
            got_zero_q  <= got_zero_d;
            out_sr_q    <= out_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            resp_len_q  <= resp_len_d;
            has_data_q  <= has_data_d;
            byte_cnt_q  <= byte_cnt_d;
            miso_q      <= miso_d;
            dat_req_q   <= dat_req_d;
            idle_q      <= idle_d;
            acmd_cnt_q  <= acmd_cnt_d;
            app_q       <= app_d;
            init_done_q <= init_done_d;
            blk_addr_q  <= blk_addr_d;
        end
    end

    assign sd_miso   = miso_q;
    assign init_done = init_done_q;
    assign blk_addr  = blk_addr_q;
    assign dat_req   = dat_req_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Testbench for sd_spi_responder: acts as an SPI-mode host, keeps a behavioural
// card model (status flags and expected byte stream) and compares every received byte.
`timescale 1ns/1ps
module tb_sd_spi_responder;

    localparam int          HALF         = 4;
    localparam int          INIT_RETRIES = 3;
    localparam int          NCR_BYTES    = 1;
    localparam logic [31:0] OCR_VALUE    = 32'hC0FF8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_ck = 1'b0;
    logic        sd_csn = 1'b1;
    logic        sd_mosi = 1'b1;
    logic        sd_miso;
    logic        init_done;
    logic [31:0] blk_addr;
    logic        dat_req;
    logic [7:0]  dat_in = 8'h00;

    always #5 clk = ~clk;

    sd_spi_responder #(
        .INIT_RETRIES (INIT_RETRIES),
        .NCR_BYTES    (NCR_BYTES),
        .OCR_VALUE    (OCR_VALUE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sd_ck     (sd_ck),
        .sd_csn    (sd_csn),
        .sd_mosi   (sd_mosi),
        .sd_miso   (sd_miso),
        .init_done (init_done),
        .blk_addr  (blk_addr),
        .dat_req   (dat_req),
        .dat_in    (dat_in)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural card model
    bit          m_idle = 1'b1;
    int          m_cnt  = INIT_RETRIES;
    bit          m_app  = 1'b0;
    bit          m_init = 1'b0;
    logic [31:0] m_blk  = 32'h0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] prov_q[$];
    bit         exp_data;
    bit         idx_mode = 1'b1;
    int         req_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] frame);
        logic [6:0] c;
        logic       top;
        c = 7'h00;
        for (int i = 0; i < 40; i++) begin
            top = c[6];
            c   = {c[5:0], 1'b0};
            if (frame[39 - i] ^ top) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Data source: hand out either the byte index or a random byte per request
    initial begin
        forever begin
            @(negedge clk);
            if (dat_req) begin
                if (idx_mode) dat_in = 8'(req_cnt);
                else          dat_in = 8'($urandom);
                prov_q.push_back(dat_in);
                req_cnt++;
            end
        end
    end

    // With chip select high for a few clks the card must be driving 1
    initial begin
        int hi;
        hi = 0;
        forever begin
            @(negedge clk);
            if (sd_csn) hi++; else hi = 0;
            if (hi >= 4 && rst_n) check("miso_idle", 32'(sd_miso), 32'd1);
        end
    end

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sd_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = sd_miso;
            sd_ck = 1'b1;
            repeat (HALF) @(negedge clk);
            sd_ck = 1'b0;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int s = 24; s >= 0; s -= 8) exp_q.push_back(8'(w >> s));
    endtask

    // Expected byte stream and card-state update for one well-framed command
    task automatic model_cmd(input logic [5:0] cmd, input logic [31:0] arg, input bit crc_ok);
        logic [7:0] r1i;
        exp_q.delete();
        exp_data = 1'b0;
        for (int i = 0; i < NCR_BYTES; i++) exp_q.push_back(8'hFF);
        r1i = m_idle ? 8'h01 : 8'h00;
        if (!crc_ok) begin
            exp_q.push_back(8'h08 | r1i);
            return;
        end
        case (cmd)
            6'd0: begin
                exp_q.push_back(8'h01);
                m_idle = 1'b1; m_init = 1'b0; m_cnt = INIT_RETRIES;
            end
            6'd8: begin
                exp_q.push_back(r1i);
                push_word(arg & 32'h0000_0FFF);
            end
            6'd55: exp_q.push_back(r1i);
            6'd41: begin
                if (!m_app) exp_q.push_back(8'h04 | r1i);
                else if (m_cnt > 0) begin
                    m_cnt--;
                    exp_q.push_back(8'h01);
                end else begin
                    exp_q.push_back(8'h00);
                    m_idle = 1'b0; m_init = 1'b1;
                end
            end
            6'd58: begin
                exp_q.push_back(r1i);
                push_word((OCR_VALUE & ~32'h4000_0000) | (m_idle ? 32'h0 : 32'h4000_0000));
            end
            6'd17: begin
                if (m_idle) exp_q.push_back(8'h05);
                else begin
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'hFF);
                    exp_q.push_back(8'hFE);
                    m_blk    = arg;
                    exp_data = 1'b1;
                end
            end
            default: exp_q.push_back(8'h04 | r1i);
        endcase
        m_app = (cmd == 6'd55);
    endtask

    // crc_mode: 0 good frame, 1 CRC field wrong, 2 stop bit 0. abort_after < 0 reads a full block.
    task automatic run_cmd(input logic [5:0] cmd, input logic [31:0] arg,
                           input int crc_mode, input int abort_after);
        logic [39:0] head;
        logic [6:0]  c;
        logic [7:0]  crcb, b, e;
        bit          crc_ok;
        int          nd;
        head = {2'b01, cmd, arg};
        c    = crc7(head);
        crcb = {c, 1'b1};
        if (crc_mode == 1) crcb = {((c == 7'h00) ? 7'h01 : 7'h00), 1'b1};
        if (crc_mode == 2) crcb = {c, 1'b0};
`ifdef SD_CRC_CHECK_EN
        crc_ok = (crc_mode != 1);
`else
        crc_ok = 1'b1;
`endif
        rx_q.delete();
        prov_q.delete();
        req_cnt = 0;
        sd_csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 4; i >= 0; i--) xfer(head[i*8 +: 8], b);
        xfer(crcb, b);
        if (crc_mode == 2) begin
            exp_q.delete();
            exp_data = 1'b0;
            for (int i = 0; i < NCR_BYTES + 1; i++) exp_q.push_back(8'hFF);
        end else begin
            model_cmd(cmd, arg, crc_ok);
        end
        foreach (exp_q[i]) begin
            xfer(8'hFF, b);
            rx_q.push_back(b);
            check($sformatf("cmd%0d_byte%0d", cmd, i), 32'(b), 32'(exp_q[i]));
        end
        if (exp_data) begin
            nd = (abort_after >= 0) ? abort_after : 512;
            for (int j = 0; j < nd; j++) begin
                xfer(8'hFF, b);
                rx_q.push_back(b);
                check($sformatf("cmd17_req_before_byte%0d", j), 32'(prov_q.size() > j), 32'd1);
                if (idx_mode) e = 8'(j);
                else          e = (j < prov_q.size()) ? prov_q[j] : 8'h00;
                check($sformatf("cmd17_data%0d", j), 32'(b), 32'(e));
            end
            if (abort_after < 0) begin
                for (int j = 0; j < 2; j++) begin
                    xfer(8'hFF, b);
                    rx_q.push_back(b);
                    check("cmd17_dcrc", 32'(b), 32'hFF);
                end
                check("dat_req_count", 32'(req_cnt), 32'd512);
            end
        end else begin
            xfer(8'hFF, b);
            rx_q.push_back(b);
            check($sformatf("cmd%0d_trail", cmd), 32'(b), 32'hFF);
            check($sformatf("cmd%0d_no_req", cmd), 32'(req_cnt), 32'd0);
        end
        sd_mosi = 1'b1;
        sd_csn  = 1'b1;
        repeat (6) @(negedge clk);
        check("init_done", 32'(init_done), 32'(m_init));
        check("blk_addr", blk_addr, m_blk);
        $display("cmd%0d arg=%h crc_mode=%0d abort=%0d bytes=%0d r1=%h",
                 cmd, arg, crc_mode, abort_after, rx_q.size(), rx_q[NCR_BYTES]);
    endtask

    initial begin
        logic [7:0] r41[4];
        int         pick;
        logic [5:0] rc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(sd_miso), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_blk_addr", blk_addr, 32'd0);
        check("rst_dat_req", 32'(dat_req), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Pin the CRC7 helper to the well-known CMD0 and CMD8 frame CRCs
        check("crc7_cmd0", 32'(crc7({2'b01, 6'd0, 32'h0})), 32'h4A);
        check("crc7_cmd8", 32'(crc7({2'b01, 6'd8, 32'h1AA})), 32'h43);

        run_cmd(6'd0, 32'h0, 0, -1);
        check("cmd0_ncr_lit", 32'(rx_q[0]), 32'hFF);
        check("cmd0_r1_lit", 32'(rx_q[1]), 32'h01);

        run_cmd(6'd8, 32'h0000_01AA, 0, -1);
        check("cmd8_lit", {rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, 32'h0100_0001);
        check("cmd8_lit_last", 32'(rx_q[5]), 32'hAA);

        run_cmd(6'd17, 32'h0000_0100, 0, -1);
        check("cmd17_idle_lit", 32'(rx_q[1]), 32'h05);

        run_cmd(6'd41, 32'h4000_0000, 0, -1);
        check("cmd41_noapp_lit", 32'(rx_q[1]), 32'h05);

        for (int k = 0; k < 4; k++) begin
            check("init_before_acmd41", 32'(init_done), 32'd0);
            run_cmd(6'd55, 32'h0, 0, -1);
            run_cmd(6'd41, 32'h4000_0000, 0, -1);
            r41[k] = rx_q[1];
        end
        check("acmd41_seq_lit", {r41[0], r41[1], r41[2], r41[3]}, 32'h0101_0100);
        check("init_after_acmd41", 32'(init_done), 32'd1);

        run_cmd(6'd58, 32'h0, 0, -1);
        check("cmd58_lit", {rx_q[2], rx_q[3], rx_q[4], rx_q[5]}, 32'hC0FF_8000);
        check("cmd58_r1_lit", 32'(rx_q[1]), 32'h00);

        idx_mode = 1'b1;
        run_cmd(6'd17, 32'h0000_0010, 0, -1);
        check("rd_r1_lit", 32'(rx_q[1]), 32'h00);
        check("rd_gap_lit", 32'(rx_q[2]), 32'hFF);
        check("rd_token_lit", 32'(rx_q[3]), 32'hFE);
        check("rd_d0_lit", 32'(rx_q[4]), 32'h00);
        check("rd_d255_lit", 32'(rx_q[4 + 255]), 32'hFF);
        check("rd_d256_lit", 32'(rx_q[4 + 256]), 32'h00);
        check("rd_d300_lit", 32'(rx_q[4 + 300]), 32'h2C);
        check("rd_crc_lit", {rx_q[516], rx_q[517]}, 32'h0000_FFFF);
        check("rd_blk_addr_lit", blk_addr, 32'h0000_0010);

        // Stop bit 0: silently dropped, card stays ready
        run_cmd(6'd0, 32'h0, 2, -1);
        run_cmd(6'd58, 32'h0, 0, -1);
        check("after_badstop_ccs", 32'(rx_q[2]), 32'hC0);

        // Abort a read mid-data, then a fresh CMD0 must answer normally
        idx_mode = 1'b0;
        run_cmd(6'd17, $urandom, 0, 5);
        check("abort_miso", 32'(sd_miso), 32'd1);
        run_cmd(6'd0, 32'h0, 0, -1);
        check("abort_cmd0_lit", 32'(rx_q[1]), 32'h01);

        // CMD0 with a zero CRC field
        run_cmd(6'd0, 32'h0, 1, -1);
`ifdef SD_CRC_CHECK_EN
        check("badcrc_cmd0_lit", 32'(rx_q[1]), 32'h09);
`else
        check("badcrc_cmd0_lit", 32'(rx_q[1]), 32'h01);
`endif

        // Randomized command mix against the model
        for (int t = 0; t < 14; t++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0: run_cmd(6'd0, $urandom, ($urandom_range(0, 7) == 0) ? 1 : 0, -1);
                1: run_cmd(6'd8, $urandom, ($urandom_range(0, 7) == 0) ? 1 : 0, -1);
                2, 3, 4: begin
                    run_cmd(6'd55, $urandom, 0, -1);
                    run_cmd(6'd41, $urandom, ($urandom_range(0, 7) == 0) ? 1 : 0, -1);
                end
                5: run_cmd(6'd41, $urandom, 0, -1);
                6: run_cmd(6'd58, $urandom, 0, -1);
                7: run_cmd(6'd17, $urandom, 0, $urandom_range(1, 4));
                8: begin
                    case ($urandom_range(0, 3))
                        0:       rc = 6'd9;
                        1:       rc = 6'd13;
                        2:       rc = 6'd16;
                        default: rc = 6'd59;
                    endcase
                    run_cmd(rc, $urandom, 0, -1);
                end
                default: run_cmd(6'd55, $urandom, 0, -1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
